exc_vector_seq: RTL
===================

# exc_vector_seq

Exception-vector fetch sequencer that owns the memory-address mux selector (IorD) of the multicycle core. In normal operation it passes the control unit's IorD choice and memory write strobe through. On an exception it stalls the control unit, saves EPC, steers the mux to the vector address, waits out memory latency and loads PC with the fetched vector byte.

## Interface
- MEM_LAT, 2: memory read latency in cycles, legal range 1..7.
- clk  in  1  core clock.
- reset_n  in  1  asynchronous, active-low reset.
- cu_iord  in  3  IorD selector requested by the control unit.
- cu_mem_wr  in  1  memory write strobe from the control unit.
- exc_opcode  in  1  invalid-opcode exception, sampled at clk edge.
- exc_ovf  in  1  arithmetic overflow exception.
- exc_div0  in  1  divide-by-zero exception.
- iord_sel  out  3  selector driven to the memory-address mux.
- mem_wr  out  1  gated memory write strobe.
- exc_stall  out  1  holds the control unit in its current state.
- epc_wr  out  1  EPC load enable.
- pc_wr_exc  out  1  PC load enable for the vector.
- pc_src_exc  out  1  selects zero-extended memory byte [7:0] as the PC source.
- exc_cause  out  2  last accepted cause: 1 = opcode, 2 = overflow, 3 = div0, 0 = none.
- exc_done  out  1  one-cycle pulse when PC is loaded.

## Operation
- Selector codes: 0 = PC, 2 = vector 254 (opcode), 3 = vector 255 (overflow), 4 = vector 253 (div0).
- States: IDLE, SAVE, FETCH, LOAD.
- IDLE: iord_sel = cu_iord, mem_wr = cu_mem_wr, other outputs 0. Any exception input high at an edge moves the block to SAVE and latches the cause and vector code.
- Priority on simultaneous exceptions: opcode > overflow > div0. Losers are dropped.
- SAVE, one cycle: epc_wr = 1, exc_stall = 1, mem_wr = 0, iord_sel = 0. Then FETCH, with the wait counter loaded to MEM_LAT-1.
- FETCH: iord_sel = latched vector code, exc_stall = 1, mem_wr = 0. The counter decrements each cycle. At 0 the block moves to LOAD.
- LOAD, one cycle: iord_sel held, pc_src_exc = 1, pc_wr_exc = 1, exc_done = 1, exc_stall = 1. Then IDLE.
- Exception inputs are ignored outside IDLE and are not queued.
- exc_cause updates on entry to SAVE and holds until the next accepted exception.
- mem_wr is forced to 0 in every non-IDLE state.

## Timing
- All outputs are Moore (a function of registered state), except in IDLE, where iord_sel and mem_wr are combinational pass-throughs of cu_iord and cu_mem_wr.
- Exception sampled at edge E: SAVE is active in cycle E+1, FETCH in cycles E+2..E+1+MEM_LAT, LOAD in E+2+MEM_LAT, IDLE in E+3+MEM_LAT.
- exc_stall is high for MEM_LAT+2 cycles.
- An exception input high on the edge that leaves LOAD is ignored. The first acceptable edge is the one ending the first IDLE cycle.
- Reset values: state IDLE, counter 0, exc_cause 0, every output 0 except the pass-throughs.
- reset_n low mid-sequence aborts immediately to IDLE. No PC or EPC write occurs after the assertion.

## Configuration
- EXC_DIV0_EN defined: exc_div0 is honoured, uses code 4 and cause 3.
- EXC_DIV0_EN undefined: exc_div0 is ignored and never changes state, and selector code 4 is never driven by the sequencer.

## Structure
- Shared package exc_pkg holds:
  - the state enum;
  - selector-code constants (SEL_PC, SEL_VEC_OPC, SEL_VEC_OVF, SEL_VEC_DIV0);
  - cause constants.
- One sub-module, exc_prio_enc: a combinational priority encoder from the three exception inputs to {valid, cause, selector code}, honouring EXC_DIV0_EN.

## Test plan
- Idle pass-through: cu_iord = 5, cu_mem_wr = 1, no exception -> iord_sel = 5, mem_wr = 1, exc_stall = 0.
- Overflow pulse, MEM_LAT = 2:
  - next cycle epc_wr = 1;
  - then 2 cycles with iord_sel = 3;
  - then pc_wr_exc = pc_src_exc = exc_done = 1;
  - exc_stall high 4 cycles, exc_cause = 2.
- exc_opcode and exc_ovf high together -> iord_sel = 2 in FETCH, exc_cause = 1.
- exc_div0 pulse during FETCH of an opcode exception -> ignored, and only one exc_done occurs.
- reset_n low during FETCH -> iord_sel = cu_iord, no pc_wr_exc, exc_cause = 0.
- Built without EXC_DIV0_EN: exc_div0 = 1 -> no stall, exc_cause unchanged.

Source files
------------

// File: rtl/exc_pkg.sv
// rtl/exc_pkg.sv - shared states, selector codes and cause codes for the exception-vector sequencer
package exc_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SAVE  = 2'd1,
        ST_FETCH = 2'd2,
        ST_LOAD  = 2'd3
    } exc_state_e;

    // Memory-address mux selector codes
    localparam logic [2:0] SEL_PC       = 3'd0;
    localparam logic [2:0] SEL_VEC_OPC  = 3'd2;
    localparam logic [2:0] SEL_VEC_OVF  = 3'd3;
    localparam logic [2:0] SEL_VEC_DIV0 = 3'd4;

    localparam logic [1:0] CAUSE_NONE = 2'd0;
    localparam logic [1:0] CAUSE_OPC  = 2'd1;
    localparam logic [1:0] CAUSE_OVF  = 2'd2;
    localparam logic [1:0] CAUSE_DIV0 = 2'd3;

endpackage

// File: rtl/exc_prio_enc.sv
// rtl/exc_prio_enc.sv - exception priority encoder (opcode > overflow > div0); div0 honoured only with EXC_DIV0_EN
module exc_prio_enc
    import exc_pkg::*;
(
    input  logic       i_opcode,
    input  logic       i_ovf,
    input  logic       i_div0,
    output logic       o_valid,
    output logic [1:0] o_cause,
    output logic [2:0] o_sel
);

`ifdef EXC_DIV0_EN
    localparam logic DIV0_EN = 1'b1;
`else
    localparam logic DIV0_EN = 1'b0;
`endif

    logic w_div0_req;

    // With the feature off the request folds to constant 0 and the div0 path prunes away
    assign w_div0_req = i_div0 & DIV0_EN;

    always_comb begin
        o_valid = 1'b0;
        o_cause = CAUSE_NONE;
        o_sel   = SEL_PC;
        if (i_opcode) begin
            o_valid = 1'b1;
            o_cause = CAUSE_OPC;
            o_sel   = SEL_VEC_OPC;
        end else if (i_ovf) begin
            o_valid = 1'b1;
            o_cause = CAUSE_OVF;
            o_sel   = SEL_VEC_OVF;
        end else if (w_div0_req) begin
            o_valid = 1'b1;
            o_cause = CAUSE_DIV0;
            o_sel   = SEL_VEC_DIV0;
        end
    end

endmodule

// File: rtl/exc_vector_seq.sv
// rtl/exc_vector_seq.sv - exception-vector fetch sequencer owning the IorD mux selector (optional EXC_DIV0_EN)
module exc_vector_seq
    import exc_pkg::*;
#(
    parameter int MEM_LAT = 2
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] cu_iord,
    input  logic       cu_mem_wr,
    input  logic       exc_opcode,
    input  logic       exc_ovf,
    input  logic       exc_div0,
    output logic [2:0] iord_sel,
    output logic       mem_wr,
    output logic       exc_stall,
    output logic       epc_wr,
    output logic       pc_wr_exc,
    output logic       pc_src_exc,
    output logic [1:0] exc_cause,
    output logic       exc_done
);

    localparam int CNT_W = 3;

    exc_state_e       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [1:0]       r_cause;
    logic [2:0]       r_vec;
    logic [2:0]       r_iord;
    logic             r_stall;
    logic             r_epc_wr;
    logic             r_pc_wr;
    logic             r_pc_src;
    logic             r_done;

    logic             w_exc_valid;
    logic [1:0]       w_exc_cause;
    logic [2:0]       w_exc_sel;
    logic             w_idle;

    exc_prio_enc u_prio_enc (
        .i_opcode (exc_opcode),
        .i_ovf    (exc_ovf),
        .i_div0   (exc_div0),
        .o_valid  (w_exc_valid),
        .o_cause  (w_exc_cause),
        .o_sel    (w_exc_sel)
    );

    // Registered outputs are loaded with the values of the state being entered
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_cause  <= CAUSE_NONE;
            r_vec    <= SEL_PC;
            r_iord   <= SEL_PC;
            r_stall  <= 1'b0;
            r_epc_wr <= 1'b0;
            r_pc_wr  <= 1'b0;
            r_pc_src <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_exc_valid) begin
                        r_state  <= ST_SAVE;
                        r_cause  <= w_exc_cause;
                        r_vec    <= w_exc_sel;
                        r_iord   <= SEL_PC;
                        r_stall  <= 1'b1;
                        r_epc_wr <= 1'b1;
                    end
                end
                ST_SAVE: begin
                    r_state  <= ST_FETCH;
                    r_cnt    <= CNT_W'(MEM_LAT - 1);
                    r_iord   <= r_vec;
                    r_epc_wr <= 1'b0;
                end
                ST_FETCH: begin
                    if (r_cnt == '0) begin
                        r_state  <= ST_LOAD;
                        r_pc_wr  <= 1'b1;
                        r_pc_src <= 1'b1;
                        r_done   <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                ST_LOAD: begin
                    r_state  <= ST_IDLE;
                    r_iord   <= SEL_PC;
                    r_stall  <= 1'b0;
                    r_pc_wr  <= 1'b0;
                    r_pc_src <= 1'b0;
                    r_done   <= 1'b0;
                end
                default: begin
                    r_state  <= ST_IDLE;
                    r_iord   <= SEL_PC;
                    r_stall  <= 1'b0;
                    r_epc_wr <= 1'b0;
                    r_pc_wr  <= 1'b0;
                    r_pc_src <= 1'b0;
                    r_done   <= 1'b0;
                end
            endcase
        end
    end

    assign w_idle     = (r_state == ST_IDLE);
    assign iord_sel   = w_idle ? cu_iord : r_iord;
    assign mem_wr     = w_idle & cu_mem_wr;
    assign exc_stall  = r_stall;
    assign epc_wr     = r_epc_wr;
    assign pc_wr_exc  = r_pc_wr;
    assign pc_src_exc = r_pc_src;
    assign exc_cause  = r_cause;
    assign exc_done   = r_done;

endmodule
